addacc_serial_acc: RTL



---
 rtl/addacc_pkg.sv | 16 +
 rtl/addacc_serial_fa.sv | 29 ++
 rtl/addacc_serial_acc.sv | 123 ++++++++++++
 3 files changed

// File: rtl/addacc_pkg.sv
// Shared types and constants for the bit-serial accumulator stage.
package addacc_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Width of the per-word bit counter; it must hold 0..width-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/addacc_serial_fa.sv
// One-bit full adder with a registered carry. `start` forces the carry-in
// to zero so the LSB of every word begins a fresh addition.
module addacc_serial_fa (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic start,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  logic carry_q;
  logic carry_in;

  assign carry_in = start ? 1'b0 : carry_q;
  assign sum      = a ^ b ^ carry_in;
  assign carry    = (a & b) | (a & carry_in) | (b & carry_in);

  // Hold the carry between accepted bits; stalls leave it untouched.
  always_ff @(posedge clk) begin
    // NOTE: registers use <= so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) carry_q <= 1'b0;
    else if (en) carry_q <= carry;
  end

endmodule

// File: rtl/addacc_serial_acc.sv
// Bit-serial accumulator: adds LSB-first framed words from the DRO chain
// into a WIDTH-bit running sum, reporting it with a valid strobe, a sticky
// overflow flag and a framing-error strobe.
module addacc_serial_acc
  import addacc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             word_start,
  input  logic             clear,
  output logic [WIDTH-1:0] acc_out,
  output logic             acc_valid,
  output logic             overflow,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shadow;
  logic [CW-1:0]    bit_cnt;
  logic             clear_pend;

  logic             clear_eff;
  logic             accept_start;
  logic             accept_bit;
  logic             last_bit;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] new_acc;
  logic             fa_sum;
  logic             fa_carry;

  assign clear_eff    = clear | clear_pend;
  assign accept_start = bit_valid & word_start;
  assign accept_bit   = bit_valid & ~word_start & (state == ACCUM);
  assign last_bit     = accept_bit & (bit_cnt == LAST);
  assign busy         = (state == ACCUM);

  // Pick the word the current bit is added into: a new word starts from the
  // committed sum, an aborted one from the shadow, a cleared one from zero.
  always_comb begin
    // NOTE: default first so every path assigns base and no latch is inferred.
    base = acc;
    if (accept_start) begin
      if (clear_eff) base = '0;
      else if (state == ACCUM) base = shadow;
    end
  end

  addacc_serial_fa u_fa (
    .clk  (clk),
    .rst  (rst),
    .en   (accept_start | accept_bit),
    .start(accept_start),
    .a    (base[0]),
    .b    (bit_in),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  // Sum bits enter at the top; after WIDTH shifts the word is realigned.
  assign new_acc = {fa_sum, base[WIDTH-1:1]};

  // FSM, shift register, shadow, clear handling and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      shadow     <= '0;
      bit_cnt    <= '0;
      clear_pend <= 1'b0;
      acc_out    <= '0;
      acc_valid  <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      frame_err <= 1'b0;
      if (accept_start) begin
        // Restart mid-word is a framing error; the partial word is dropped.
        frame_err  <= (state == ACCUM);
        shadow     <= base;
        acc        <= new_acc;
        bit_cnt    <= CW'(1);
        state      <= ACCUM;
        clear_pend <= 1'b0;
        if (clear_eff) begin
          acc_out  <= '0;
          overflow <= 1'b0;
        end
      end else if (state == IDLE) begin
        if (bit_valid) frame_err <= 1'b1;
        if (clear_eff) begin
          acc        <= '0;
          acc_out    <= '0;
          overflow   <= 1'b0;
          clear_pend <= 1'b0;
        end
      end else begin
        // Clear mid-word waits until the word completes or is aborted.
        if (clear) clear_pend <= 1'b1;
        if (accept_bit) begin
          acc     <= new_acc;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            acc_out   <= new_acc;
            acc_valid <= 1'b1;
            overflow  <= overflow | fa_carry;
            state     <= IDLE;
          end
        end
      end
    end
  end

endmodule
